exmem_stage_skid: RTL and testbench

Parametrised EX/MEM pipeline stage for the five-stage core: it registers execute-stage results and memory/write-back control into the memory stage. It supports a valid/ready handshake with a 2-entry skid buffer, so the memory stage can stall without a combinational ready path back into execute. A flush input squashes in-flight instructions for branch mispredicts. Squashed and empty slots present as bubbles, with all control outputs at 0.

---
 rtl/exmem_stage_skid.sv | 173 +++++++++++++++++
 tb/tb_exmem_stage_skid.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage_skid.sv
// EX/MEM pipeline stage with a two-entry skid buffer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on the same side. in_ready depends only on registered state and on
// rst_n, never on out_ready. out_valid is a decode of registered state.
// Output payload always comes from the head register M, so in_* has no
// combinational path to *_out.
//
// Squashed and empty slots are bubbles. Their control bits are cleared in M
// whenever the stage becomes empty, so control outputs read 0 while out_valid
// is 0.
module exmem_stage_skid #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              regwrite_in,
    input  logic              memtoreg_in,
    input  logic              memwrite_in,
    input  logic              memread_in,
    input  logic              branch_in,
    input  logic              zflag_in,
    input  logic [DATA_W-1:0] branch_result_in,
    input  logic [DATA_W-1:0] alures_in,
    input  logic [DATA_W-1:0] data2_in,
    input  logic [REG_W-1:0]  instruccion_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              regwrite_out,
    output logic              memtoreg_out,
    output logic              memwrite_out,
    output logic              memread_out,
    output logic              branch_out,
    output logic              zflag_out,
    output logic [DATA_W-1:0] branch_result_out,
    output logic [DATA_W-1:0] alures_out,
    output logic [DATA_W-1:0] data2_out,
    output logic [REG_W-1:0]  instruccion_out,
    output logic [1:0]        count,
    output logic [1:0]        state_o
);

    // The state encoding equals the occupancy, so count is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
        logic              memread;
        logic              branch;
        logic              zflag;
        logic [DATA_W-1:0] branch_result;
        logic [DATA_W-1:0] alures;
        logic [DATA_W-1:0] data2;
        logic [REG_W-1:0]  instruccion;
    } entry_t;

    state_t state_q, state_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    // Turns an entry into a bubble; data fields are left as they were.
    function automatic entry_t clear_ctrl(input entry_t e);
        entry_t r;
        r          = e;
        r.regwrite = 1'b0;
        r.memtoreg = 1'b0;
        r.memwrite = 1'b0;
        r.memread  = 1'b0;
        r.branch   = 1'b0;
        r.zflag    = 1'b0;
        return r;
    endfunction

    assign in_entry.regwrite      = regwrite_in;
    assign in_entry.memtoreg      = memtoreg_in;
    assign in_entry.memwrite      = memwrite_in;
    assign in_entry.memread       = memread_in;
    assign in_entry.branch        = branch_in;
    assign in_entry.zflag         = zflag_in;
    assign in_entry.branch_result = branch_result_in;
    assign in_entry.alures        = alures_in;
    assign in_entry.data2         = data2_in;
    assign in_entry.instruccion   = instruccion_in;

    assign in_ready  = rst_n & (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state and next-payload selection; flush overrides normal flow.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = ST_EMPTY;
            m_d     = clear_ctrl(m_q);
            s_d     = clear_ctrl(s_q);
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        m_d     = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (pop && accept) begin
                        m_d = in_entry;
                    end else if (pop) begin
                        m_d     = clear_ctrl(m_q);
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        s_d     = in_entry;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        m_d     = s_q;
                        s_d     = clear_ctrl(s_q);
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    m_d     = clear_ctrl(m_q);
                    s_d     = clear_ctrl(s_q);
                end
            endcase
        end
    end

    // State and storage registers; reset clears every field, data included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign regwrite_out      = m_q.regwrite;
    assign memtoreg_out      = m_q.memtoreg;
    assign memwrite_out      = m_q.memwrite;
    assign memread_out       = m_q.memread;
    assign branch_out        = m_q.branch;
    assign zflag_out         = m_q.zflag;
    assign branch_result_out = m_q.branch_result;
    assign alures_out        = m_q.alures;
    assign data2_out         = m_q.data2;
    assign instruccion_out   = m_q.instruccion;
    assign count             = state_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_exmem_stage_skid.sv
// Directed bench for exmem_stage_skid: reset, streaming, skid stall,
// flush, bubble and reset during a stall.
module tb_exmem_stage_skid;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              regwrite_in, memtoreg_in, memwrite_in, memread_in, branch_in, zflag_in;
    logic [DATA_W-1:0] branch_result_in, alures_in, data2_in;
    logic [REG_W-1:0]  instruccion_in;
    logic              out_valid;
    logic              out_ready;
    logic              regwrite_out, memtoreg_out, memwrite_out, memread_out, branch_out, zflag_out;
    logic [DATA_W-1:0] branch_result_out, alures_out, data2_out;
    logic [REG_W-1:0]  instruccion_out;
    logic [1:0]        count;
    logic [1:0]        state_o;

    int checks_total  = 0;
    int checks_passed = 0;

    exmem_stage_skid #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
        .memread_in(memread_in), .branch_in(branch_in), .zflag_in(zflag_in),
        .branch_result_in(branch_result_in), .alures_in(alures_in), .data2_in(data2_in),
        .instruccion_in(instruccion_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out), .memwrite_out(memwrite_out),
        .memread_out(memread_out), .branch_out(branch_out), .zflag_out(zflag_out),
        .branch_result_out(branch_result_out), .alures_out(alures_out), .data2_out(data2_out),
        .instruccion_out(instruccion_out),
        .count(count), .state_o(state_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one offered instruction; the payload is derived from the value a.
    task automatic set_in(input logic v, input logic [31:0] a, input logic ctl);
        in_valid         = v;
        alures_in        = a;
        regwrite_in      = ctl;
        memtoreg_in      = ctl;
        memwrite_in      = ctl;
        memread_in       = ctl;
        branch_in        = ctl;
        zflag_in         = ctl;
        branch_result_in = a + 32'h100;
        data2_in         = ~a;
        instruccion_in   = a[4:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ctrl"}, {26'd0, regwrite_out, memtoreg_out, memwrite_out,
                             memread_out, branch_out, zflag_out}, 32'd0);
        chk({tag, "_count"}, {30'd0, count}, 32'd0);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a, input logic [1:0] cnt);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_alures"}, alures_out, a);
        chk({tag, "_count"}, {30'd0, count}, {30'd0, cnt});
    endtask

    initial begin
        // Reset with an offered instruction
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_in(1'b1, 32'hAA, 1'b1);
        #1;
        chk("rst_in_ready_comb", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        chk_bubble("rst");
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_alures", alures_out, 32'd0);
        chk("rst_branch_result", branch_result_out, 32'd0);
        chk("rst_data2", data2_out, 32'd0);
        chk("rst_instr", {27'd0, instruccion_out}, 32'd0);
        rst_n = 1'b1;
        set_in(1'b0, 32'h0, 1'b0);
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b1, i, 1'b1);
            tick();
            chk_head("stream", i, 2'd1);
            chk("stream_regwrite", {31'd0, regwrite_out}, 32'd1);
            chk("stream_branch_result", branch_result_out, i + 32'h100);
            chk("stream_data2", data2_out, ~i);
            chk("stream_instr", {27'd0, instruccion_out}, i & 32'h1f);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        set_in(1'b0, 32'h0, 1'b0);
        tick();
        chk_bubble("stream_drain");

        // Stall and skid
        out_ready = 1'b0;
        set_in(1'b1, 32'h10, 1'b1);
        tick();
        chk_head("skid_a", 32'h10, 2'd1);
        set_in(1'b1, 32'h20, 1'b1);
        tick();
        chk_head("skid_full", 32'h10, 2'd2);
        chk("skid_in_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_state", {30'd0, state_o}, 32'd2);
        set_in(1'b1, 32'h30, 1'b1);
        tick();
        chk_head("skid_hold", 32'h10, 2'd2);
        set_in(1'b0, 32'h0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_head("skid_pop_a", 32'h20, 2'd1);
        chk("skid_pop_a_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_bubble("skid_empty");

        // Flush in FULL with a new offer
        out_ready = 1'b0;
        set_in(1'b1, 32'h41, 1'b1);
        tick();
        set_in(1'b1, 32'h42, 1'b1);
        tick();
        chk_head("fl_full", 32'h41, 2'd2);
        flush = 1'b1;
        set_in(1'b1, 32'h99, 1'b1);
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 1'b0);
        chk_bubble("fl_full");
        out_ready = 1'b1;
        tick();
        chk_bubble("fl_full_after");

        // Flush in ONE while in_ready is high: the offer is still dropped
        out_ready = 1'b0;
        set_in(1'b1, 32'h51, 1'b1);
        tick();
        chk_head("fl_one", 32'h51, 2'd1);
        flush = 1'b1;
        set_in(1'b1, 32'h77, 1'b1);
        #1;
        chk("fl_one_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 1'b0);
        chk_bubble("fl_one");

        // Bubble: control inputs without valid never reach the outputs
        out_ready = 1'b1;
        set_in(1'b0, 32'h33, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bubble_memwrite", {31'd0, memwrite_out}, 32'd0);
            chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
        end

        // Reset while FULL
        out_ready = 1'b0;
        set_in(1'b1, 32'h61, 1'b1);
        tick();
        set_in(1'b1, 32'h62, 1'b1);
        tick();
        chk_head("rs_full", 32'h61, 2'd2);
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 1'b0);
        tick();
        chk_bubble("rs");
        chk("rs_alures", alures_out, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'h5, 1'b1);
        tick();
        chk_head("rs_push", 32'h5, 2'd1);
        chk("rs_push_branch_result", branch_result_out, 32'h105);
        set_in(1'b0, 32'h0, 1'b0);
        tick();
        chk_bubble("rs_drain");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
